// File: rtl/demux1_2_reg.sv
// demux1_2_reg: registered 1:2 valid/ready demultiplexer with per-port delivered-word counters
//
// Routes one upstream stream to one of two downstream ports, chosen per word by s_sel.
// Each port owns a one-entry holding register, so a stalled port never blocks the other.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   s_data/s_sel/s_valid  upstream word, destination select (0 -> port 0, 1 -> port 1), presence
//   s_ready               word for the selected port can be taken this cycle
//   m0_data/m0_valid      port-0 registered word and presence, m0_ready from consumer
//   m1_data/m1_valid      port-1 registered word and presence, m1_ready from consumer
//   m0_count/m1_count     words delivered per port, wrapping
module demux1_2_reg #(
    parameter int DW   = 19,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   s_data,
    input  logic            s_sel,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [DW-1:0]   m0_data,
    output logic            m0_valid,
    input  logic            m0_ready,
    output logic [DW-1:0]   m1_data,
    output logic            m1_valid,
    input  logic            m1_ready,
    output logic [CNTW-1:0] m0_count,
    output logic [CNTW-1:0] m1_count
);
    logic [DW-1:0]   m0_data_q, m0_data_d, m1_data_q, m1_data_d;
    logic            m0_valid_q, m0_valid_d, m1_valid_q, m1_valid_d;
    logic [CNTW-1:0] m0_count_q, m0_count_d, m1_count_q, m1_count_d;
    logic            slot0_free, slot1_free, acc0, acc1, drn0, drn1;
    // A slot is free when empty or when its word leaves on this edge, allowing drain and refill together.
    always_comb begin
        slot0_free = !m0_valid_q | m0_ready;
        slot1_free = !m1_valid_q | m1_ready;
        s_ready    = s_sel ? slot1_free : slot0_free;
        acc0       = s_valid & s_ready & !s_sel;
        acc1       = s_valid & s_ready & s_sel;
        drn0       = m0_valid_q & m0_ready;
        drn1       = m1_valid_q & m1_ready;
        m0_valid_d = acc0 | (m0_valid_q & !m0_ready);
        m1_valid_d = acc1 | (m1_valid_q & !m1_ready);
        m0_data_d  = acc0 ? s_data : m0_data_q;
        m1_data_d  = acc1 ? s_data : m1_data_q;
        m0_count_d = m0_count_q + CNTW'(drn0);
        m1_count_d = m1_count_q + CNTW'(drn1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_data_q  <= '0;
            m1_data_q  <= '0;
            m0_valid_q <= 1'b0;
            m1_valid_q <= 1'b0;
            m0_count_q <= '0;
            m1_count_q <= '0;
        end else begin
            m0_data_q  <= m0_data_d;
            m1_data_q  <= m1_data_d;
            m0_valid_q <= m0_valid_d;
            m1_valid_q <= m1_valid_d;
            m0_count_q <= m0_count_d;
            m1_count_q <= m1_count_d;
        end
    end
    assign m0_data  = m0_data_q;
    assign m1_data  = m1_data_q;
    assign m0_valid = m0_valid_q;
    assign m1_valid = m1_valid_q;
    assign m0_count = m0_count_q;
    assign m1_count = m1_count_q;
endmodule

// File: tb/tb_demux1_2_reg.sv
// tb_demux1_2_reg: scoreboard bench for demux1_2_reg with a narrow-counter twin for wrap checks
module tb_demux1_2_reg;
    localparam int DW = 19;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] s_data = '0, m0_data, m1_data, w_m0_data, w_m1_data;
    logic s_sel = 1'b0, s_valid = 1'b0, s_ready, w_s_ready;
    logic m0_valid, m1_valid, w_m0_valid, w_m1_valid;
    logic m0_ready = 1'b1, m1_ready = 1'b1;
    logic [15:0] m0_count, m1_count;
    logic [3:0] w_m0_count, w_m1_count;
    int errors = 0, checks = 0, n0 = 0, n1 = 0, w = 0;
    logic done = 1'b0;
    logic [DW-1:0] exp0[$], exp1[$];
    logic [DW-1:0] rd;
    always #5 clk = ~clk;
    demux1_2_reg #(.DW(DW), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_sel(s_sel), .s_valid(s_valid), .s_ready(s_ready),
        .m0_data(m0_data), .m0_valid(m0_valid), .m0_ready(m0_ready),
        .m1_data(m1_data), .m1_valid(m1_valid), .m1_ready(m1_ready),
        .m0_count(m0_count), .m1_count(m1_count));
    demux1_2_reg #(.DW(DW), .CNTW(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_sel(s_sel), .s_valid(s_valid), .s_ready(w_s_ready),
        .m0_data(w_m0_data), .m0_valid(w_m0_valid), .m0_ready(m0_ready),
        .m1_data(w_m1_data), .m1_valid(w_m1_valid), .m1_ready(m1_ready),
        .m0_count(w_m0_count), .m1_count(w_m1_count));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic send(input logic [DW-1:0] d, input logic sel, output int t);
        t = 0;
        s_data = d;
        s_sel = sel;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", {31'd0, s_ready}, 32'd1);
        if (!s_ready) begin
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (sel) exp1.push_back(d);
        else exp0.push_back(d);
        #1;
    endtask
    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            n0 = 0;
            n1 = 0;
        end else begin
            chk("m0_count", {16'd0, m0_count}, n0);
            chk("m1_count", {16'd0, m1_count}, n1);
            chk("w_m0_count", {28'd0, w_m0_count}, n0 % 16);
            chk("w_m1_count", {28'd0, w_m1_count}, n1 % 16);
            chk("twin_s_ready", {31'd0, w_s_ready}, {31'd0, s_ready});
            if (m0_valid && m0_ready) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL m0_spurious: got %0h expected no word", m0_data);
                end else begin
                    rd = exp0.pop_front();
                    if (m0_data !== rd) begin
                        errors++;
                        $display("FAIL m0_data: got %0h expected %0h", m0_data, rd);
                    end
                end
                n0++;
            end
            if (m1_valid && m1_ready) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL m1_spurious: got %0h expected no word", m1_data);
                end else begin
                    rd = exp1.pop_front();
                    if (m1_data !== rd) begin
                        errors++;
                        $display("FAIL m1_data: got %0h expected %0h", m1_data, rd);
                    end
                end
                n1++;
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        #1;
        chk("rst_m0_valid", {31'd0, m0_valid}, 0);
        chk("rst_m1_valid", {31'd0, m1_valid}, 0);
        chk("rst_m0_data", {13'd0, m0_data}, 0);
        chk("rst_m1_data", {13'd0, m1_data}, 0);
        chk("rst_m0_count", {16'd0, m0_count}, 0);
        chk("rst_m1_count", {16'd0, m1_count}, 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(19'h7FFFF, 1'b0, w);
        chk("route_m0_valid", {31'd0, m0_valid}, 1);
        chk("route_m0_data", {13'd0, m0_data}, 32'h7FFFF);
        send(19'h00001, 1'b1, w);
        chk("route_m1_valid", {31'd0, m1_valid}, 1);
        chk("route_m1_data", {13'd0, m1_data}, 32'h00001);
        idle(2);
        chk("route_m0_count", {16'd0, m0_count}, 1);
        chk("route_m1_count", {16'd0, m1_count}, 1);
        for (int i = 0; i < 8; i++) begin
            send(19'(i * 4099 + 17), 1'b0, w);
            chk("stream_stall", w, 0);
            chk("stream_m0_valid", {31'd0, m0_valid}, 1);
            chk("stream_m0_data", {13'd0, m0_data}, i * 4099 + 17);
        end
        idle(2);
        chk("stream_m0_count", {16'd0, m0_count}, 9);
        m0_ready = 1'b0;
        send(19'h0ABCD, 1'b0, w);
        s_valid = 1'b0;
        s_sel = 1'b0;
        #1 chk("bp_ready_sel0", {31'd0, s_ready}, 0);
        s_sel = 1'b1;
        #1 chk("bp_ready_sel1", {31'd0, s_ready}, 1);
        send(19'h12345, 1'b1, w);
        chk("bp_m1_data", {13'd0, m1_data}, 32'h12345);
        idle(1);
        chk("bp_m0_hold_valid", {31'd0, m0_valid}, 1);
        chk("bp_m0_hold_data", {13'd0, m0_data}, 32'h0ABCD);
        chk("bp_m1_count", {16'd0, m1_count}, 2);
        m0_ready = 1'b1;
        send(19'h2AAAA, 1'b0, w);
        chk("refill_stall", w, 0);
        chk("refill_m0_valid", {31'd0, m0_valid}, 1);
        chk("refill_m0_data", {13'd0, m0_data}, 32'h2AAAA);
        idle(2);
        chk("refill_m0_count", {16'd0, m0_count}, 11);
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        send(19'h11111, 1'b0, w);
        send(19'h22222, 1'b1, w);
        s_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        exp0.delete();
        exp1.delete();
        chk("mid_rst_m0_valid", {31'd0, m0_valid}, 0);
        chk("mid_rst_m1_valid", {31'd0, m1_valid}, 0);
        chk("mid_rst_m0_count", {16'd0, m0_count}, 0);
        chk("mid_rst_m1_count", {16'd0, m1_count}, 0);
        chk("mid_rst_m0_data", {13'd0, m0_data}, 0);
        s_sel = 1'b0;
        #1 chk("mid_rst_ready0", {31'd0, s_ready}, 1);
        s_sel = 1'b1;
        #1 chk("mid_rst_ready1", {31'd0, s_ready}, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        m1_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(19'(i + 32'h40000), 1'b1, w);
        idle(2);
        chk("wrap_m1_count", {16'd0, m1_count}, 17);
        chk("wrap_w_m1_count", {28'd0, w_m1_count}, 1);
        fork
            while (!done) begin
                @(posedge clk);
                #1;
                m0_ready = 1'($urandom_range(1));
                m1_ready = 1'($urandom_range(1));
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send(19'($urandom), 1'($urandom_range(1)), w);
                end
                s_valid = 1'b0;
                done = 1'b1;
            end
        join
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        idle(3);
        chk("rand_exp0_left", exp0.size(), 0);
        chk("rand_exp1_left", exp1.size(), 0);
        chk("rand_m0_idle", {31'd0, m0_valid}, 0);
        chk("rand_m1_idle", {31'd0, m1_valid}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
